// File: rtl/arch_pkg.sv
// Shared widths, reset/bubble constants and the fetch FSM encoding for the
// instruction-fetch stage.
package arch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INST = 32'hF000_0000;
    localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry {instruction, pc} holding register that catches a fetch which
// completes while the IF/ID register is frozen.
module fetch_skid_reg
    import arch_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pc_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] pc_o
);
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_q, pc_d;

    // Clear (redirect) wins over load, load wins over unload.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// drives the IF/ID register, with freeze, branch redirect and a skid entry.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = arch_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST = arch_pkg::NOP_INST
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        inst_valid,
    output logic [1:0]  dbg_state_o
);
    import arch_pkg::*;

    // Handshake: imem_req/imem_addr are registered and held until a cycle
    // with imem_req && imem_ack; that cycle is the transfer (may be the first).
    fetch_state_t state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic         valid_q, valid_d;

    logic         xfer, accept;
    logic         skid_valid;
    logic [31:0]  skid_instr, skid_pc;

    assign xfer   = req_q && imem_ack;
    assign accept = (state_q == WAIT) && xfer && !Branch_taken;

    fetch_skid_reg u_skid (
        .CLK      (CLK),
        .RST      (RST),
        .load_i   (accept && freeze),
        .unload_i (!Branch_taken && !freeze && skid_valid),
        .clear_i  (Branch_taken),
        .instr_i  (imem_rdata),
        .pc_i     (pc_q + 32'd4),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        if (Branch_taken) begin
            pc_d    = Branch_Address & 32'hFFFF_FFFC;
            instr_d = NOP_INST;
            valid_d = 1'b0;
            // An in-flight request must finish before the target is issued.
            if (state_q != IDLE) begin
                if (xfer) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
        end else begin
            if (!freeze) begin
                if (skid_valid) begin
                    instr_d = skid_instr;
                    ifpc_d  = skid_pc;
                    valid_d = 1'b1;
                end else if (accept) begin
                    instr_d = imem_rdata;
                    ifpc_d  = pc_q + 32'd4;
                    valid_d = 1'b1;
                end else begin
                    instr_d = NOP_INST;
                    valid_d = 1'b0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (!skid_valid || !freeze) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (xfer) begin
                        pc_d = pc_q + 32'd4;
                        if (freeze) begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            addr_d = pc_q + 32'd4;
                        end
                    end
                end
                DROP: begin
                    if (xfer) begin
                        addr_d  = pc_q;
                        state_d = WAIT;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INST;
            ifpc_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign Instruction = instr_q;
    assign PC          = ifpc_q;
    assign inst_valid  = valid_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against a transaction-level model.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] Branch_Address = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        inst_valid;
  logic [1:0]  dbg_state;

  if_fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .freeze         (freeze),
    .Branch_taken   (Branch_taken),
    .Branch_Address (Branch_Address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .Instruction    (Instruction),
    .PC             (PC),
    .inst_valid     (inst_valid),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // memory image: every word is a distinct, decodable, non-NOP instruction
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {4'hE, a[27:2], 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // instruction memory responder: random latency per request
  int lat_lo = 0;
  int lat_hi = 0;
  int lat = 0;
  bit lat_set = 1'b0;
  bit ack_in_reset = 1'b0;

  always @(negedge CLK) begin
    if (!RST) begin
      imem_ack = ack_in_reset;
      lat_set  = 1'b0;
    end else if (imem_req) begin
      if (!lat_set) begin
        lat     = int'($urandom_range(lat_hi, lat_lo));
        lat_set = 1'b1;
      end
      if (lat == 0) begin
        imem_ack = 1'b1;
        lat_set  = 1'b0;
      end else begin
        imem_ack = 1'b0;
        lat--;
      end
    end else begin
      imem_ack = 1'b0;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
  end

  // reference model: one outstanding request, a queue of held words
  logic [31:0] m_next = 32'h0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = 32'h0;
  bit          m_busy = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_valid = 1'b0;
  logic [63:0] m_held[$];
  bit          m_done, m_got, m_had;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_next = 32'h0; m_addr = 32'h0; m_busy = 1'b0; m_stale = 1'b0;
      m_held.delete();
      m_instr = NOP; m_pc = 32'h0; m_valid = 1'b0;
    end else begin
      m_done = m_busy && imem_ack;
      m_had  = m_held.size() > 0;
      if (Branch_taken) begin
        m_next  = Branch_Address & 32'hFFFF_FFFC;
        m_instr = NOP;
        m_valid = 1'b0;
        m_held.delete();
        if (m_done) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else if (m_busy) begin
          m_stale = 1'b1;
        end
      end else begin
        m_got = m_done && !m_stale;
        if (!freeze) begin
          if (m_had) begin
            {m_instr, m_pc} = m_held.pop_front();
            m_valid = 1'b1;
          end else if (m_got) begin
            m_instr = mem_word(m_addr);
            m_pc    = m_addr + 32'd4;
            m_valid = 1'b1;
          end else begin
            m_instr = NOP;
            m_valid = 1'b0;
          end
        end else if (m_got) begin
          m_held.push_back({mem_word(m_addr), m_addr + 32'd4});
        end
        if (!m_busy) begin
          if (!m_had || !freeze) begin
            m_busy = 1'b1;
            m_addr = m_next;
          end
        end else if (m_done) begin
          if (m_stale) begin
            m_stale = 1'b0;
            m_addr  = m_next;
          end else begin
            m_next = m_next + 32'd4;
            if (freeze) m_busy = 1'b0;
            else        m_addr = m_next;
          end
        end
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge CLK) begin
    chk1("imem_req", imem_req, m_busy);
    if (m_busy) chk("imem_addr", imem_addr, m_addr);
    chk1("inst_valid", inst_valid, m_valid);
    chk("Instruction", Instruction, m_instr);
    if (m_valid) begin
      chk("PC", PC, m_pc);
      chk("inst_matches_pc", Instruction, mem_word(PC - 32'd4));
    end
  end

  // driver tasks
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset(input int lo, input int hi);
    RST = 1'b0;
    freeze = 1'b0;
    Branch_taken = 1'b0;
    lat_lo = lo;
    lat_hi = hi;
    step();
    step();
    RST = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_instr"}, Instruction, NOP);
    chk({tag, "_pc"}, PC, 32'h0);
    chk1({tag, "_valid"}, inst_valid, 1'b0);
    chk({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
  endtask

  initial begin
    // T1: zero-wait memory, one instruction per cycle
    step();
    chk_reset_vals("t1_reset");
    RST = 1'b1;
    step(); chk("t1_addr0", imem_addr, 32'h0); chk1("t1_req", imem_req, 1'b1);
    step(); chk("t1_addr4", imem_addr, 32'h4); chk("t1_pc4", PC, 32'h4);
            chk1("t1_valid", inst_valid, 1'b1); chk("t1_instr0", Instruction, 32'hE000_0003);
    step(); chk("t1_addr8", imem_addr, 32'h8); chk("t1_pc8", PC, 32'h8);
    step(); chk("t1_pc12", PC, 32'hC); chk("t1_instr8", Instruction, 32'hE000_000B);

    // T2: three wait states
    do_reset(3, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_addr_held", imem_addr, 32'h0);
      chk1("t2_bubble_valid", inst_valid, 1'b0);
      chk("t2_bubble_instr", Instruction, NOP);
    end
    step(); chk1("t2_valid", inst_valid, 1'b1); chk("t2_pc", PC, 32'h4);

    // T3: freeze while the ack arrives
    do_reset(2, 2);
    step();
    step(); freeze = 1'b1;
    step(); chk1("t3_req_wait", imem_req, 1'b1); chk("t3_addr", imem_addr, 32'h0);
    step(); chk1("t3_req_idle", imem_req, 1'b0); chk1("t3_held_valid", inst_valid, 1'b0);
            chk("t3_state_idle", {30'b0, dbg_state}, 32'd0);
    step(); chk1("t3_req_still0", imem_req, 1'b0); freeze = 1'b0;
    step(); chk1("t3_drain_valid", inst_valid, 1'b1); chk("t3_drain_pc", PC, 32'h4);
            chk("t3_drain_instr", Instruction, 32'hE000_0003);
            chk1("t3_req_next", imem_req, 1'b1); chk("t3_addr_next", imem_addr, 32'h4);
    step(); chk1("t3_no_dup", inst_valid, 1'b0);
    step();
    step(); chk1("t3_next_valid", inst_valid, 1'b1); chk("t3_next_pc", PC, 32'h8);

    // T4: branch while waiting on 0x8
    do_reset(0, 0);
    step();
    step(); lat_lo = 2; lat_hi = 2;
    step(); chk("t4_addr8", imem_addr, 32'h8); chk("t4_pc8", PC, 32'h8);
            Branch_taken = 1'b1; Branch_Address = 32'h100;
    step(); Branch_taken = 1'b0; lat_lo = 0; lat_hi = 0;
            chk("t4_state_drop", {30'b0, dbg_state}, 32'd2);
            chk("t4_addr_stable", imem_addr, 32'h8); chk1("t4_nop", inst_valid, 1'b0);
    step(); chk1("t4_dropped", inst_valid, 1'b0);
    step(); chk("t4_addr_target", imem_addr, 32'h100); chk1("t4_req", imem_req, 1'b1);
    step(); chk("t4_pc_target", PC, 32'h104); chk("t4_instr", Instruction, 32'hE000_0103);

    // T5: branch and freeze together with the skid full
    do_reset(0, 0);
    step(); freeze = 1'b1;
    step(); chk1("t5_req0", imem_req, 1'b0);
            Branch_taken = 1'b1; Branch_Address = 32'h203;
    step(); Branch_taken = 1'b0; freeze = 1'b0;
            chk1("t5_nop", inst_valid, 1'b0); chk("t5_nop_instr", Instruction, NOP);
    step(); chk("t5_addr_target", imem_addr, 32'h200); chk1("t5_skid_cleared", inst_valid, 1'b0);
    step(); chk("t5_pc", PC, 32'h204); chk("t5_instr", Instruction, 32'hE000_0203);

    // T6: reset in the middle of a wait, ack during reset
    do_reset(5, 5);
    step(); chk1("t6_req", imem_req, 1'b1);
    step(); RST = 1'b0; ack_in_reset = 1'b1;
    step(); chk_reset_vals("t6_reset");
    step(); RST = 1'b1; ack_in_reset = 1'b0;
    step(); chk1("t6_req_after", imem_req, 1'b1); chk("t6_addr_after", imem_addr, 32'h0);
            chk1("t6_valid_after", inst_valid, 1'b0);

    // T7: redirect with same-cycle ack, then PC wrap at the top of memory
    do_reset(0, 0);
    step(); Branch_taken = 1'b1; Branch_Address = 32'hFFFF_FFF8;
    step(); Branch_taken = 1'b0;
            chk1("t7_req_idle", imem_req, 1'b0); chk1("t7_dropped", inst_valid, 1'b0);
    step(); chk("t7_addr_fff8", imem_addr, 32'hFFFF_FFF8);
    step(); chk("t7_pc_fffc", PC, 32'hFFFF_FFFC);
    step(); chk("t7_pc_wrap", PC, 32'h0); chk("t7_instr_top", Instruction, 32'hEFFF_FFFF);
            chk("t7_addr_wrap", imem_addr, 32'h0);
    step(); chk("t7_pc4", PC, 32'h4);

    // randomized run
    do_reset(0, 3);
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i % 500 == 0) begin
        lat_lo = 0;
        lat_hi = int'($urandom_range(0, 4));
      end
      if (!RST) begin
        RST = 1'b1;
        ack_in_reset = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        RST = 1'b0;
        ack_in_reset = 1'($urandom_range(0, 1));
      end
      freeze = ($urandom_range(0, 9) < 3);
      Branch_taken = ($urandom_range(0, 99) < 8);
      Branch_Address = ($urandom_range(0, 3) == 0) ?
                       32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) :
                       32'($urandom_range(0, 4095));
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
